clk_div_duty: RTL and testbench

CLK_DIV_DUTY -- requirements
Module: clk_div_duty

---
 rtl/clk_div_duty.sv | 161 ++++++++++++++++
 tb/tb_clk_div_duty.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_duty.sv
// ---------------------------------------------------------------------------
// clk_div_duty -- programmable clock divider with duty-cycle control.
//
// Produces a registered divided clock whose period is N clockin cycles.
// clockout is high for the first min(H, N) cycles of every period.
// A new N/H pair is loaded into shadow registers with a one-cycle load
// strobe. The shadow pair is applied only at a period boundary, or on the
// next edge while idle, so the output never shows a runt or stretched pulse.
//
// Optional feature macro: CLK_DIV_TICK_EN
//   defined   : tick is a registered one-cycle pulse at each period start
//   undefined : tick is tied to 0 and its register is not built
//
// Handshake: load is a plain one-cycle strobe with no back-pressure.
//   A load is accepted on the edge where it is sampled high. An accepted
//   load sets pending on the next edge. A rejected load (div_value < 2)
//   pulses cfg_err for exactly one cycle and leaves shadow/pending alone.
//
// Ports:
//   clockin    in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   enable     in   run request. Dropping it lets the current period finish
//   load       in   capture div_value/high_count into the shadow registers
//   div_value  in   requested divisor N (2 .. 2^WIDTH-1)
//   high_count in   requested high cycles H per period
//   clockout   out  registered divided clock
//   tick       out  registered pulse in the first cycle of each period
//   pending    out  shadow configuration waiting to be applied
//   cfg_err    out  one-cycle pulse on a rejected load
// ---------------------------------------------------------------------------
module clk_div_duty #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 6,
  parameter int DEFAULT_HIGH = 3
) (
  input  logic             clockin,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] div_value,
  input  logic [WIDTH-1:0] high_count,
  output logic             clockout,
  output logic             tick,
  output logic             pending,
  output logic             cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] n_sh_q, n_sh_d;
  logic [WIDTH-1:0] h_sh_q, h_sh_d;
  logic             pending_d;
  logic             clockout_d;
  logic             cfg_err_d;
  logic             load_ok;
  logic             boundary;
  logic             apply;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    h_d        = h_q;
    n_sh_d     = n_sh_q;
    h_sh_d     = h_sh_q;
    pending_d  = pending;
    cfg_err_d  = 1'b0;
    clockout_d = 1'b0;

    load_ok  = load && (div_value >= TWO);
    // Last cycle of the current period. The next edge starts a new period.
    boundary = (state_q == RUN) && (cnt_q == n_q - ONE);
    apply    = pending && ((state_q == IDLE) || boundary);

    // The registered shadow is applied first. A load on this same edge is
    // written afterwards, so it waits for the following boundary.
    if (apply) begin
      n_d       = n_sh_q;
      h_d       = h_sh_q;
      pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = ZERO;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (boundary) begin
          cnt_d = ZERO;
          // Stopping only at a boundary means a period is never cut short.
          if (!enable) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO;
      end
    endcase

    if (load_ok) begin
      n_sh_d    = div_value;
      h_sh_d    = high_count;
      pending_d = 1'b1;
    end
    if (load && !load_ok) cfg_err_d = 1'b1;

    // The comparison uses the next count and the next active H, so a newly
    // applied H takes effect in the very first cycle of the new period.
    clockout_d = (state_d == RUN) && (cnt_d < h_d);
  end

  always_ff @(posedge clockin) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= ZERO;
      n_q      <= DEF_N;
      h_q      <= DEF_H;
      n_sh_q   <= DEF_N;
      h_sh_q   <= DEF_H;
      pending  <= 1'b0;
      clockout <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      h_q      <= h_d;
      n_sh_q   <= n_sh_d;
      h_sh_q   <= h_sh_d;
      pending  <= pending_d;
      clockout <= clockout_d;
      cfg_err  <= cfg_err_d;
    end
  end

`ifdef CLK_DIV_TICK_EN
  always_ff @(posedge clockin) begin
    if (reset) tick <= 1'b0;
    else       tick <= (state_d == RUN) && (cnt_d == ZERO);
  end
`else
  assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_duty.sv
// ---------------------------------------------------------------------------
// Testbench for clk_div_duty.
//
// The reference model describes the output as the position within the
// current period:
//   clockout = running && (pos < H)
//   tick     = running && (pos == 0)
// Configuration changes are applied between periods.
//
// The driver issues one input vector per cycle on the falling edge. It
// advances the model and pushes the expected output word. The monitor pops
// one word after every rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_clk_div_duty;

  localparam int WIDTH = 8;

  logic             clockin = 1'b0;
  logic             reset   = 1'b1;
  logic             enable  = 1'b0;
  logic             load    = 1'b0;
  logic [WIDTH-1:0] div_value  = '0;
  logic [WIDTH-1:0] high_count = '0;
  logic             clockout, tick, pending, cfg_err;

  clk_div_duty #(
    .WIDTH(WIDTH),
    .DEFAULT_DIV(6),
    .DEFAULT_HIGH(3)
  ) dut (
    .clockin   (clockin),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .div_value (div_value),
    .high_count(high_count),
    .clockout  (clockout),
    .tick      (tick),
    .pending   (pending),
    .cfg_err   (cfg_err)
  );

  // ---------------- clock ----------------
  always #5 clockin = ~clockin;

  // ---------------- scoreboard state ----------------
  // Each expected word is {clockout, tick, pending, cfg_err}.
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // ---------------- reference model ----------------
  bit m_run  = 1'b0;
  int m_pos  = 0;
  int m_n    = 6;
  int m_h    = 3;
  int m_sn   = 6;
  int m_sh   = 3;
  bit m_pend = 1'b0;

  task automatic model_step(input bit rst, input bit en, input bit ld,
                            input int dv, input int hc);
    bit err;
    bit clk_e;
    bit tick_e;
    err = 1'b0;
    if (rst) begin
      m_run  = 1'b0;
      m_pos  = 0;
      m_n    = 6;
      m_h    = 3;
      m_sn   = 6;
      m_sh   = 3;
      m_pend = 1'b0;
    end else begin
      if (!m_run) begin
        if (m_pend) begin
          m_n    = m_sn;
          m_h    = m_sh;
          m_pend = 1'b0;
        end
        m_pos = 0;
        if (en) m_run = 1'b1;
      end else if (m_pos == m_n - 1) begin
        if (m_pend) begin
          m_n    = m_sn;
          m_h    = m_sh;
          m_pend = 1'b0;
        end
        m_pos = 0;
        if (!en) m_run = 1'b0;
      end else begin
        m_pos = m_pos + 1;
      end
      if (ld && dv >= 2) begin
        m_sn   = dv;
        m_sh   = hc;
        m_pend = 1'b1;
      end
      err = ld && (dv < 2);
    end
    clk_e = m_run && (m_pos < m_h);
`ifdef CLK_DIV_TICK_EN
    tick_e = m_run && (m_pos == 0);
`else
    tick_e = 1'b0;
`endif
    exp_q.push_back({clk_e, tick_e, m_pend, err});
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit en, input bit ld,
                      input int dv, input int hc);
    @(negedge clockin);
    reset      = rst;
    enable     = en;
    load       = ld;
    div_value  = dv[WIDTH-1:0];
    high_count = hc[WIDTH-1:0];
    model_step(rst, en, ld, dv, hc);
  endtask

  task automatic run_cycles(input bit en, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, en, 1'b0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clockin) begin
    logic [3:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({clockout, tick, pending, cfg_err} !== e) begin
        n_fail++;
        $display("FAIL outputs at %0t: clockout/tick/pending/cfg_err got %b%b%b%b required %b",
                 $time, clockout, tick, pending, cfg_err, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit en_r;
    bit rst_r;
    bit ld_r;
    int dv_r;
    int hc_r;

    // Reset, then run on the defaults: 3 high / 3 low.
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    run_cycles(1'b1, 20);

    // Stop, load N=5 H=2 while idle, then run.
    run_cycles(1'b0, 8);
    step(1'b0, 1'b0, 1'b1, 5, 2);
    run_cycles(1'b0, 2);
    run_cycles(1'b1, 15);

    // N=4 H=4 gives a constant high output.
    step(1'b0, 1'b1, 1'b1, 4, 4);
    run_cycles(1'b1, 16);

    // Reload while running: the current period keeps its length.
    step(1'b1, 1'b0, 1'b0, 0, 0);
    run_cycles(1'b1, 3);
    step(1'b0, 1'b1, 1'b1, 8, 2);
    run_cycles(1'b1, 20);

    // Drop enable mid-period, then restart.
    step(1'b1, 1'b0, 1'b0, 0, 0);
    run_cycles(1'b1, 2);
    run_cycles(1'b0, 10);
    run_cycles(1'b1, 10);

    // H=0: constant low output.
    step(1'b0, 1'b1, 1'b1, 3, 0);
    run_cycles(1'b1, 10);

    // Rejected load, then a mid-period reset.
    step(1'b1, 1'b0, 1'b0, 0, 0);
    run_cycles(1'b1, 2);
    step(1'b0, 1'b1, 1'b1, 1, 0);
    step(1'b0, 1'b1, 1'b1, 0, 5);
    run_cycles(1'b1, 1);
    step(1'b1, 1'b1, 1'b1, 9, 9);
    run_cycles(1'b1, 8);

    // Randomized phase.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      ld_r = ($urandom_range(0, 11) == 0);
      dv_r = $urandom_range(0, 12);
      if ($urandom_range(0, 40) == 0) dv_r = $urandom_range(200, 255);
      hc_r = $urandom_range(0, 14);
      step(rst_r, en_r, ld_r, dv_r, hc_r);
    end

    // Let the monitor consume the last expected word.
    @(posedge clockin);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
